spi_slave_responder: RTL

Single-channel SPI responder (slave) for the RHS2116 link, speaking the same protocol as the `spi_verilog` master: mode 0 (CPOL=0, CPHA=0), MSB first, one word per CS-low frame. It oversamples `cs`/`sclk` in the system clock domain, delivers each received command word to the fabric, and shifts out a fabric-supplied response word. It serves two purposes: an on-fabric chip model for closed-loop master verification, and the front end of a chip-emulator target.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_edge_sync.sv | 34 +++
 rtl/spi_slave_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the RHS2116 link: mode constants, default word size and
// the responder state encoding.
package spi_pkg;

  localparam int unsigned SPI_CPOL            = 0;
  localparam int unsigned SPI_CPHA            = 0;
  localparam int unsigned DEFAULT_WORD_LENGTH = 32;

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StActive,
    StDone
  } spi_state_e;

  // Width of a bit counter that must hold 0..max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizer chain for one SPI input plus rise/fall detection on the synchronized level.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI responder: oversamples cs/sclk/mosi, delivers received words and shifts out
// a fabric-supplied response word held in a holding register.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs,
  input  logic                   sclk,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   data_in_v,
  output logic [WORD_LENGTH-1:0] data_out,
  output logic                   data_out_v,
  output logic                   frame_err,
  output logic                   tx_underrun
);

  localparam int unsigned   CntW    = cnt_width(WORD_LENGTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(WORD_LENGTH);
  localparam logic [CntW-1:0] CntSat  = CntW'(WORD_LENGTH + 1);

  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_mosi;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_cs_sync (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_d    (cs),
    .o_level(w_cs_level),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sclk_sync (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_d    (sclk),
    .o_level(w_sclk_level),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // mosi gets the same depth as sclk so data is aligned with the detected edge.
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_mosi_sync[i] <= r_mosi_sync[i-1];
      end
    end
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  spi_state_e             r_state;
  logic [WORD_LENGTH-1:0] r_hold;
  logic                   r_loaded;
  logic [WORD_LENGTH-1:0] r_shift_tx;
  logic [WORD_LENGTH-1:0] r_shift_rx;
  logic [CntW-1:0]        r_cnt;
  logic                   r_miso;
  logic [WORD_LENGTH-1:0] r_data_out;
  logic                   r_data_out_v;
  logic                   r_frame_err;
  logic                   r_tx_underrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StWaitIdle;
      r_hold        <= '0;
      r_loaded      <= 1'b0;
      r_shift_tx    <= '0;
      r_shift_rx    <= '0;
      r_cnt         <= '0;
      r_miso        <= 1'b0;
      r_data_out    <= '0;
      r_data_out_v  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_data_out_v  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_underrun <= 1'b0;

      if (data_in_v) begin
        r_hold   <= data_in;
        r_loaded <= 1'b1;
      end

      unique case (r_state)
        StWaitIdle: begin
          if (w_cs_level) r_state <= StIdle;
        end
        StIdle: begin
          if (w_cs_fall) begin
            // Old holding value goes out; a coincident load is kept for the next frame.
            r_shift_tx    <= r_hold;
            r_miso        <= r_hold[WORD_LENGTH-1];
            r_cnt         <= '0;
            r_tx_underrun <= ~r_loaded;
            r_loaded      <= data_in_v;
            r_state       <= StActive;
          end
        end
        StActive: begin
          if (w_cs_rise) begin
            r_miso  <= 1'b0;
            r_state <= StDone;
          end else begin
            if (w_sclk_rise) begin
              r_shift_rx <= {r_shift_rx[WORD_LENGTH-2:0], w_mosi};
              if (r_cnt != CntSat) r_cnt <= r_cnt + 1'b1;
            end
            if (w_sclk_fall) begin
              r_shift_tx <= {r_shift_tx[WORD_LENGTH-2:0], 1'b0};
              r_miso     <= r_shift_tx[WORD_LENGTH-2];
            end
          end
        end
        StDone: begin
          if (r_cnt == CntFull) begin
            r_data_out   <= r_shift_rx;
            r_data_out_v <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
          r_state <= StIdle;
        end
        default: r_state <= StWaitIdle;
      endcase
    end
  end

  assign miso        = r_miso;
  assign data_out    = r_data_out;
  assign data_out_v  = r_data_out_v;
  assign frame_err   = r_frame_err;
  assign tx_underrun = r_tx_underrun;

endmodule
